xor_mp_regfile: RTL and testbench
=================================

Name: xor_mp_regfile

Overview:
- Single-clock, fully parametrised multi-ported vector register file bank for a v_lane.
- Write ports are generalised to any count using XOR-coded banks: one bank per write port, each bank holding R_PORTS read copies plus (W_PORTS-1) feedback copies.
- Adds over the previous generation: byte-granular write-collision resolution, internal write-write forwarding, configurable read latency, and a hardware clear sequencer.

Parameters:
- W_PORTS, 2, number of write ports (>=1).
- R_PORTS, 4, number of read ports (>=1).
- DEPTH, 512, words per register file.
- WIDTH, 32, word width; multiple of 8.
- RD_LAT, 2, read latency in cycles; legal values 1 or 2 (2 adds an output register).
- AW, $clog2(DEPTH), address width (derived).
- NB, WIDTH/8, byte enables per word (derived).

Ports:
- clk  in  1  clock.
- rstn  in  1  reset; synchronous, active-low.
- raddr_i  in  R_PORTS*AW  read addresses.
- ren_i  in  R_PORTS  read enables.
- rdata_o  out  R_PORTS*WIDTH  read data.
- rvalid_o  out  R_PORTS  read data valid.
- waddr_i  in  W_PORTS*AW  write addresses.
- wen_i  in  W_PORTS  write enables.
- wbe_i  in  W_PORTS*NB  byte enables.
- wdata_i  in  W_PORTS*WIDTH  write data.
- wready_o  out  1  writes accepted this cycle.
- wcollision_o  out  W_PORTS  lost-byte flag per port.
- clear_i  in  1  start clear of the whole file.
- clear_busy_o  out  1  clear in progress.
- clear_done_o  out  1  one-cycle pulse when clear finishes.

Behaviour:
- Reset:
  - rvalid_o=0, rdata_o=0, wcollision_o=0, clear_busy_o=0, clear_done_o=0.
  - FSM goes to IDLE; write stage S1 is invalidated, so an in-flight write is dropped.
  - Memory contents are retained.
- Write acceptance: write p is accepted when wen_i[p] && wready_o && wbe_i[p]!=0.
  - wready_o = (state==IDLE) && !clear_i, combinational.
- Write pipeline:
  - Cycle T: accepted writes are registered into S1. Each bank issues feedback reads of waddr_i[p] on the other banks' feedback copies.
  - Cycle T+1: bank p stores wdata ^ XOR(other banks' word at that address), byte-masked by the effective bwe, into all of its copies at the end of T+1.
- Collision, same cycle, same address, overlapping bytes:
  - The lowest-indexed port wins each byte; losing ports' bytes are masked off.
  - wcollision_o[p]=1 during T+1 for each port that lost any byte; 0 otherwise.
- Write-write forwarding:
  - If a feedback word's address matches a write in S1 on that bank, the S1 stored value is substituted per enabled byte.
  - Back-to-back writes to the same address from different ports must therefore read back correctly.
- Read: address sampled at the clock edge; rdata_o and rvalid_o appear RD_LAT cycles later.
  - Data = XOR of all banks' read copy r.
  - rvalid_o[r] is ren_i[r] delayed by RD_LAT.
  - rdata_o holds its last value when ren_i=0.
- Read-after-write visibility: a read issued in cycle T+2 or later sees a write accepted in T.
  - Reads issued in T or T+1 return old data (see macro below).
- Clear FSM, states IDLE and CLEAR:
  - IDLE & clear_i → CLEAR with cnt=0. The S1 write commits at that edge.
  - CLEAR: each cycle writes 0 to address cnt in all copies of all banks (XOR of zeros = 0), then cnt++.
  - At cnt==DEPTH-1: write it, go to IDLE, and assert clear_done_o for the following cycle.
  - clear_busy_o=1 exactly DEPTH cycles. clear_i is ignored while in CLEAR.
  - Reads during CLEAR return 0 for already-cleared addresses; other addresses are unspecified; rvalid_o still follows ren_i.
- Reads to the same address from multiple ports are always legal.

Optional Feature:
- Macro XOR_MP_REGFILE_WR_BYPASS_EN.
- When defined: a read issued in T+1 to an address held in S1 returns the new word, byte-merged with the old word per effective bwe. A read in the acceptance cycle T still returns old data.
- When undefined: no read bypass; visibility as described in Behaviour.

Test Plan:
- Single write, port0 wrote 0xDEADBEEF at addr 5 (bwe=0xF); read port3 addr 5 at T+2 → rdata_o[3]=0xDEADBEEF after RD_LAT cycles, rvalid_o[3]=1.
- Both ports write addr 9 in the same cycle: p0 0x11111111 (bwe=0x3), p1 0x22222222 (bwe=0xF), prior content 0 → word=0x22221111; wcollision_o=2'b10 for one cycle.
- Back-to-back: p0 writes addr 7 =0xA5A5A5A5 at T, p1 writes addr 7 =0x0000FF00 (bwe=0x2) at T+1 → read returns 0xA5A5FFA5 (forwarding check).
- Read at T+1 after write 0x12345678 to addr 3 (old 0) → 0x00000000 without macro; 0x12345678 with macro.
- Fill all addresses, pulse clear_i with wen_i high → wready_o=0 that cycle; clear_busy_o high DEPTH=512 cycles; clear_done_o pulses once; all reads return 0.
- Assert rstn=0 the cycle after a write is accepted → write not committed; outputs reset to 0; previously committed data intact.

Source files
------------

// File: rtl/xor_mp_regfile.sv
// Multi-ported vector register file bank built from XOR-coded banks.
// One bank per write port; each bank keeps R_PORTS read copies and W_PORTS-1 feedback copies.
// The word seen by a reader is the XOR of that address across all banks.
// Optional: define XOR_MP_REGFILE_WR_BYPASS_EN to let a read one cycle after write acceptance
// see the word held in the write stage.
module xor_mp_regfile #(
  parameter int unsigned W_PORTS = 2,
  parameter int unsigned R_PORTS = 4,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned RD_LAT  = 2,
  parameter int unsigned AW      = $clog2(DEPTH),
  parameter int unsigned NB      = WIDTH / 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [R_PORTS*AW-1:0]    raddr_i,
  input  logic [R_PORTS-1:0]       ren_i,
  output logic [R_PORTS*WIDTH-1:0] rdata_o,
  output logic [R_PORTS-1:0]       rvalid_o,
  input  logic [W_PORTS*AW-1:0]    waddr_i,
  input  logic [W_PORTS-1:0]       wen_i,
  input  logic [W_PORTS*NB-1:0]    wbe_i,
  input  logic [W_PORTS*WIDTH-1:0] wdata_i,
  output logic                     wready_o,
  output logic [W_PORTS-1:0]       wcollision_o,
  input  logic                     clear_i,
  output logic                     clear_busy_o,
  output logic                     clear_done_o
);

  localparam int unsigned NCOPY = R_PORTS + W_PORTS - 1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e                              state_q, state_d;
  logic [AW-1:0]                       cnt_q, cnt_d;
  logic                                clear_done_q, clear_done_d;
  logic [W_PORTS-1:0]                  acc, coll, wcoll_q;
  logic [W_PORTS-1:0][NB-1:0]          eff_bwe;
  logic [W_PORTS-1:0]                  s1_valid_q;
  logic [W_PORTS-1:0][AW-1:0]          s1_addr_q;
  logic [W_PORTS-1:0][WIDTH-1:0]       s1_data_q;
  logic [W_PORTS-1:0][NB-1:0]          s1_bwe_q;
  logic [W_PORTS-1:0][W_PORTS-1:0][WIDTH-1:0] fb_q, fb_d;
  logic [W_PORTS-1:0][WIDTH-1:0]       bank_new;
  logic [W_PORTS-1:0][NCOPY-1:0][WIDTH-1:0] cp_rd;
  logic [W_PORTS-1:0]                  mem_we;
  logic [W_PORTS-1:0][AW-1:0]          mem_addr;
  logic [W_PORTS-1:0][WIDTH-1:0]       mem_wd, mem_msk;
  logic [R_PORTS-1:0][WIDTH-1:0]       rd1_q, rd1_d;
  logic [R_PORTS-1:0]                  rv1_q;

  function automatic logic [WIDTH-1:0] bmask(input logic [NB-1:0] be);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < NB; k++) m[8*k +: 8] = {8{be[k]}};
    return m;
  endfunction

  assign wready_o     = (state_q == StIdle) && !clear_i;
  assign wcollision_o = wcoll_q;
  assign clear_busy_o = (state_q == StClear);
  assign clear_done_o = clear_done_q;

  // Acceptance and byte-level collision resolution: lowest-indexed port keeps each byte.
  always_comb begin
    logic [NB-1:0] lost;
    acc     = '0;
    coll    = '0;
    eff_bwe = '0;
    lost    = '0;
    for (int p = 0; p < W_PORTS; p++) begin
      acc[p] = wen_i[p] && wready_o && (wbe_i[p*NB +: NB] != '0);
    end
    for (int p = 0; p < W_PORTS; p++) begin
      lost = '0;
      for (int q = 0; q < p; q++) begin
        if (acc[q] && (waddr_i[q*AW +: AW] == waddr_i[p*AW +: AW])) lost |= wbe_i[q*NB +: NB];
      end
      eff_bwe[p] = wbe_i[p*NB +: NB] & ~lost;
      coll[p]    = acc[p] && ((wbe_i[p*NB +: NB] & lost) != '0);
    end
  end

  // Word each bank stores for its S1 write; diagonal fb entries stay zero.
  always_comb begin
    bank_new = '0;
    for (int b = 0; b < W_PORTS; b++) begin
      bank_new[b] = s1_data_q[b];
      for (int q = 0; q < W_PORTS; q++) bank_new[b] ^= fb_q[b][q];
    end
  end

  // Feedback reads of other banks, with the in-flight S1 word forwarded per enabled byte.
  always_comb begin
    logic [WIDTH-1:0] m;
    fb_d = '0;
    m    = '0;
    for (int p = 0; p < W_PORTS; p++) begin
      for (int q = 0; q < W_PORTS; q++) begin
        if (q != p) begin
          fb_d[p][q] = cp_rd[q][R_PORTS + ((p < q) ? p : p - 1)];
          if (s1_valid_q[q] && (s1_addr_q[q] == waddr_i[p*AW +: AW])) begin
            m          = bmask(s1_bwe_q[q]);
            fb_d[p][q] = (bank_new[q] & m) | (fb_d[p][q] & ~m);
          end
        end
      end
    end
  end

  // Memory write port per bank: clear sweep has priority; nothing commits during reset.
  always_comb begin
    for (int b = 0; b < W_PORTS; b++) begin
      mem_we[b]   = s1_valid_q[b];
      mem_addr[b] = s1_addr_q[b];
      mem_wd[b]   = bank_new[b];
      mem_msk[b]  = bmask(s1_bwe_q[b]);
      if (state_q == StClear) begin
        mem_we[b]   = 1'b1;
        mem_addr[b] = cnt_q;
        mem_wd[b]   = '0;
        mem_msk[b]  = '1;
      end
      if (!rstn) mem_we[b] = 1'b0;
    end
  end

  for (genvar b = 0; b < W_PORTS; b++) begin : g_bank
    for (genvar c = 0; c < NCOPY; c++) begin : g_copy
      logic [AW-1:0]    rd_addr;
      logic [WIDTH-1:0] mem_q [DEPTH];
      if (c < R_PORTS) begin : g_rd
        assign rd_addr = raddr_i[c*AW +: AW];
      end else begin : g_fb
        localparam int unsigned FbPort = ((c - R_PORTS) < b) ? (c - R_PORTS) : (c - R_PORTS + 1);
        assign rd_addr = waddr_i[FbPort*AW +: AW];
      end
      assign cp_rd[b][c] = mem_q[rd_addr];
      // All copies of a bank take the same byte-masked write.
      always_ff @(posedge clk) begin
        if (mem_we[b]) begin
          mem_q[mem_addr[b]] <= (mem_wd[b] & mem_msk[b]) | (mem_q[mem_addr[b]] & ~mem_msk[b]);
        end
      end
    end
  end

  // First read stage: XOR of all banks' read copy; holds when the port is idle.
  always_comb begin
    logic [WIDTH-1:0] w, bw;
    rd1_d = rd1_q;
    w     = '0;
    bw    = '0;
    for (int r = 0; r < R_PORTS; r++) begin
      if (ren_i[r]) begin
        w = '0;
        for (int b = 0; b < W_PORTS; b++) begin
          bw = cp_rd[b][r];
`ifdef XOR_MP_REGFILE_WR_BYPASS_EN
          if (s1_valid_q[b] && (s1_addr_q[b] == raddr_i[r*AW +: AW])) begin
            bw = (bank_new[b] & bmask(s1_bwe_q[b])) | (bw & ~bmask(s1_bwe_q[b]));
          end
`endif
          w ^= bw;
        end
        rd1_d[r] = w;
      end
    end
  end

  // Clear sequencer next state: sweep every address once, then pulse done.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d      = StIdle;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and read-stage state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
      s1_valid_q   <= '0;
      wcoll_q      <= '0;
      rd1_q        <= '0;
      rv1_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
      s1_valid_q   <= acc;
      wcoll_q      <= coll;
      rd1_q        <= rd1_d;
      rv1_q        <= ren_i;
    end
  end

  // S1 payload and feedback words; only meaningful while s1_valid_q is set.
  always_ff @(posedge clk) begin
    fb_q <= fb_d;
    for (int p = 0; p < W_PORTS; p++) begin
      if (acc[p]) begin
        s1_addr_q[p] <= waddr_i[p*AW +: AW];
        s1_data_q[p] <= wdata_i[p*WIDTH +: WIDTH];
        s1_bwe_q[p]  <= eff_bwe[p];
      end
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic [R_PORTS-1:0][WIDTH-1:0] rd2_q;
    logic [R_PORTS-1:0]            rv2_q;
    // Output register stage; data only advances behind a valid read.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        rd2_q <= '0;
        rv2_q <= '0;
      end else begin
        rv2_q <= rv1_q;
        for (int r = 0; r < R_PORTS; r++) begin
          if (rv1_q[r]) rd2_q[r] <= rd1_q[r];
        end
      end
    end
    assign rdata_o  = rd2_q;
    assign rvalid_o = rv2_q;
  end else begin : g_lat1
    assign rdata_o  = rd1_q;
    assign rvalid_o = rv1_q;
  end

endmodule

// File: tb/tb_xor_mp_regfile.sv
// Scoreboard bench for xor_mp_regfile: a word-array reference model predicts read data,
// collision flags and clear timing; a negedge monitor compares whatever the DUT presents.
module tb_xor_mp_regfile;
  localparam int unsigned W_PORTS = 2;
  localparam int unsigned R_PORTS = 4;
  localparam int unsigned DEPTH   = 512;
  localparam int unsigned WIDTH   = 32;
  localparam int unsigned RD_LAT  = 2;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned NB      = WIDTH / 8;

  logic                     clk = 1'b0;
  logic                     rstn = 1'b0;
  logic [R_PORTS*AW-1:0]    raddr;
  logic [R_PORTS-1:0]       ren;
  logic [R_PORTS*WIDTH-1:0] rdata_o;
  logic [R_PORTS-1:0]       rvalid_o;
  logic [W_PORTS*AW-1:0]    waddr;
  logic [W_PORTS-1:0]       wen;
  logic [W_PORTS*NB-1:0]    wbe;
  logic [W_PORTS*WIDTH-1:0] wdata;
  logic                     wready_o;
  logic [W_PORTS-1:0]       wcollision_o;
  logic                     clear_i;
  logic                     clear_busy_o;
  logic                     clear_done_o;

  xor_mp_regfile #(
    .W_PORTS(W_PORTS), .R_PORTS(R_PORTS), .DEPTH(DEPTH), .WIDTH(WIDTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rstn(rstn), .raddr_i(raddr), .ren_i(ren), .rdata_o(rdata_o),
    .rvalid_o(rvalid_o), .waddr_i(waddr), .wen_i(wen), .wbe_i(wbe), .wdata_i(wdata),
    .wready_o(wready_o), .wcollision_o(wcollision_o), .clear_i(clear_i),
    .clear_busy_o(clear_busy_o), .clear_done_o(clear_done_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural word array plus the writes accepted last cycle.
  logic [WIDTH-1:0] mem_m [DEPTH];
  bit               pend_v  [W_PORTS];
  logic [AW-1:0]    pend_a  [W_PORTS];
  logic [WIDTH-1:0] pend_d  [W_PORTS];
  logic [NB-1:0]    pend_be [W_PORTS];

  typedef struct {
    int               due;
    int               port;
    logic [WIDTH-1:0] data;
  } rd_exp_t;
  rd_exp_t             rq[$];
  logic [W_PORTS-1:0]  exp_coll [int];
  int                  clear_start = -100000;
  bit                  mon_en = 1'b0;
  bit                  ovr_v [R_PORTS];
  logic [WIDTH-1:0]    ovr_d [R_PORTS];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h, expected 0x%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit in_clear(input int c);
    return (c > clear_start) && (c <= clear_start + int'(DEPTH));
  endfunction

  task automatic apply_pending();
    for (int p = 0; p < W_PORTS; p++) begin
      if (pend_v[p]) begin
        for (int k = 0; k < NB; k++) begin
          if (pend_be[p][k]) mem_m[pend_a[p]][8*k +: 8] = pend_d[p][8*k +: 8];
        end
        pend_v[p] = 1'b0;
      end
    end
  endtask

  // Called once per cycle with this cycle's inputs already driven.
  task automatic model_cycle();
    bit                 busy;
    bit                 exp_wready;
    logic [NB-1:0]      lost;
    logic [NB-1:0]      be;
    logic [W_PORTS-1:0] coll;
    busy       = in_clear(cyc);
    exp_wready = !busy && !clear_i;
    chk("wready", WIDTH'(wready_o), WIDTH'(exp_wready));
    if (!rstn) begin
      for (int p = 0; p < W_PORTS; p++) pend_v[p] = 1'b0;
      return;
    end
`ifdef XOR_MP_REGFILE_WR_BYPASS_EN
    apply_pending();
`endif
    for (int r = 0; r < R_PORTS; r++) begin
      if (ren[r]) begin
        rq.push_back('{cyc + int'(RD_LAT), r,
                       ovr_v[r] ? ovr_d[r] : mem_m[raddr[r*AW +: AW]]});
      end
    end
`ifndef XOR_MP_REGFILE_WR_BYPASS_EN
    apply_pending();
`endif
    if (!busy && clear_i) begin
      clear_start = cyc;
      for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    end
    coll = '0;
    for (int p = 0; p < W_PORTS; p++) begin
      be = wbe[p*NB +: NB];
      if (wen[p] && exp_wready && be != '0) begin
        lost = '0;
        for (int q = 0; q < p; q++) begin
          if (wen[q] && wbe[q*NB +: NB] != '0 && waddr[q*AW +: AW] == waddr[p*AW +: AW])
            lost |= wbe[q*NB +: NB];
        end
        coll[p]    = (be & lost) != '0;
        pend_v[p]  = 1'b1;
        pend_a[p]  = waddr[p*AW +: AW];
        pend_d[p]  = wdata[p*WIDTH +: WIDTH];
        pend_be[p] = be & ~lost;
      end
    end
    if (coll != '0) exp_coll[cyc + 1] = coll;
  endtask

  task automatic idle_inputs();
    wen = '0; wbe = '0; waddr = '0; wdata = '0;
    ren = '0; raddr = '0; clear_i = 1'b0;
    for (int r = 0; r < R_PORTS; r++) ovr_v[r] = 1'b0;
  endtask

  task automatic set_wr(input int p, input int a, input int be, input logic [WIDTH-1:0] d);
    wen[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wbe[p*NB +: NB] = NB'(be);
    wdata[p*WIDTH +: WIDTH] = d;
  endtask

  task automatic set_rd(input int r, input int a);
    ren[r] = 1'b1;
    raddr[r*AW +: AW] = AW'(a);
  endtask

  task automatic set_rd_exp(input int r, input int a, input logic [WIDTH-1:0] v);
    set_rd(r, a);
    ovr_v[r] = 1'b1;
    ovr_d[r] = v;
  endtask

  task automatic tick();
    #1;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input bit with_wr);
    idle_inputs();
    clear_i = 1'b1;
    if (with_wr) for (int p = 0; p < W_PORTS; p++) set_wr(p, $urandom_range(0, DEPTH - 1), 15, $urandom);
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      idle_inputs();
      clear_i = 1'(($urandom_range(0, 1)));
      if (with_wr) for (int p = 0; p < W_PORTS; p++) set_wr(p, $urandom_range(0, DEPTH - 1), 15, $urandom);
      tick();
    end
    idle_inputs();
    tick();
  endtask

  // Monitor: compare every presented output against the scoreboard each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      logic [R_PORTS-1:0] ev;
      logic [WIDTH-1:0]   ed [R_PORTS];
      ev = '0;
      for (int r = 0; r < R_PORTS; r++) ed[r] = '0;
      while (rq.size() > 0 && rq[0].due == cyc) begin
        ev[rq[0].port] = 1'b1;
        ed[rq[0].port] = rq[0].data;
        void'(rq.pop_front());
      end
      for (int r = 0; r < R_PORTS; r++) begin
        chk("rvalid", WIDTH'(rvalid_o[r]), WIDTH'(ev[r]));
        if (ev[r]) chk("rdata", rdata_o[r*WIDTH +: WIDTH], ed[r]);
      end
      chk("wcollision", WIDTH'(wcollision_o), WIDTH'(exp_coll.exists(cyc) ? exp_coll[cyc] : '0));
      chk("clear_busy", WIDTH'(clear_busy_o), WIDTH'(in_clear(cyc)));
      chk("clear_done", WIDTH'(clear_done_o), WIDTH'(cyc == clear_start + int'(DEPTH) + 1));
    end
  end

  initial begin
    idle_inputs();
    for (int p = 0; p < W_PORTS; p++) pend_v[p] = 1'b0;
    for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    chk("reset_rdata", rdata_o[WIDTH-1:0], '0);
    chk("reset_rdata3", rdata_o[3*WIDTH +: WIDTH], '0);
    rstn = 1'b1;
    tick();

    // Known contents everywhere.
    do_clear(1'b0);

    // Single write, read back two cycles later on port 3.
    idle_inputs(); set_wr(0, 5, 15, 32'hDEADBEEF); tick();
    idle_inputs(); tick();
    idle_inputs(); set_rd_exp(3, 5, 32'hDEADBEEF); tick();

    // Same-cycle collision on address 9.
    idle_inputs(); set_wr(0, 9, 3, 32'h11111111); set_wr(1, 9, 15, 32'h22222222); tick();
    idle_inputs(); tick();
    idle_inputs(); set_rd_exp(0, 9, 32'h22221111); tick();

    // Back-to-back writes from different ports to address 7.
    idle_inputs(); set_wr(0, 7, 15, 32'hA5A5A5A5); tick();
    idle_inputs(); set_wr(1, 7, 2, 32'h0000FF00); tick();
    idle_inputs(); tick();
    idle_inputs(); set_rd_exp(1, 7, 32'hA5A5FFA5); tick();

    // Read one cycle after the write is accepted.
    idle_inputs(); set_wr(0, 3, 15, 32'h12345678); tick();
`ifdef XOR_MP_REGFILE_WR_BYPASS_EN
    idle_inputs(); set_rd_exp(2, 3, 32'h12345678); tick();
`else
    idle_inputs(); set_rd_exp(2, 3, 32'h00000000); tick();
`endif
    idle_inputs(); set_rd_exp(2, 3, 32'h12345678); tick();

    // Random traffic on a small address window to provoke collisions and forwarding.
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      for (int p = 0; p < W_PORTS; p++)
        if ($urandom_range(0, 3) != 0) set_wr(p, $urandom_range(0, 15), $urandom_range(0, 15), $urandom);
      for (int r = 0; r < R_PORTS; r++)
        if ($urandom_range(0, 1) != 0) set_rd(r, $urandom_range(0, 15));
      tick();
    end

    // Fill every address, then clear with writes held high.
    for (int a = 0; a < DEPTH / 2; a++) begin
      idle_inputs(); set_wr(0, 2 * a, 15, $urandom); set_wr(1, 2 * a + 1, 15, $urandom); tick();
    end
    do_clear(1'b1);
    for (int a = 0; a < DEPTH; a += R_PORTS) begin
      idle_inputs();
      for (int r = 0; r < R_PORTS; r++) set_rd_exp(r, a + r, '0);
      tick();
    end

    // Reset right after a write is accepted drops it; committed data survives.
    idle_inputs(); set_wr(1, 30, 15, 32'h5A5A1234); tick();
    idle_inputs(); tick();
    idle_inputs(); set_rd_exp(0, 30, 32'h5A5A1234); tick();
    idle_inputs(); repeat (RD_LAT + 1) tick();
    idle_inputs(); set_wr(0, 20, 15, 32'hCAFEF00D); tick();
    idle_inputs(); rstn = 1'b0; tick();
    chk("reset_rdata_after", rdata_o[WIDTH-1:0], '0);
    tick();
    rstn = 1'b1;
    idle_inputs(); tick();
    idle_inputs(); set_rd_exp(1, 20, '0); set_rd_exp(2, 30, 32'h5A5A1234); tick();

    idle_inputs();
    repeat (RD_LAT + 2) tick();
    chk("scoreboard_drained", WIDTH'(rq.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
